// File: rtl/serial_link_xcvr.sv
// rtl/serial_link_xcvr.sv - framed serial transmitter and receiver sharing one clock domain
// TX emits a gated serial clock with start/data/parity/stop bits; RX samples on synchronised SCin rising edges.
module serial_link_xcvr #(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = 4,
  parameter int PARITY     = 1,
  parameter int RX_TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Send,
  input  logic [DATA_W-1:0] PDin,
  output logic              TxReady,
  output logic              SoClk,
  output logic              SDout,
  input  logic              SCin,
  input  logic              SDin,
  output logic [DATA_W-1:0] PDout,
  output logic              PDready,
  output logic              ParErr,
  output logic              FrameErr
);

  localparam int NB    = DATA_W + 2 + ((PARITY != 0) ? 1 : 0);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NB);
  localparam int RXC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_W  = $clog2(RX_TIMEOUT);

  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_END   = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NB - 1);
  localparam logic [RXC_W-1:0] DATA_LAST = RXC_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RX_TIMEOUT - 1);
  localparam logic             PAR_ODD   = (PARITY == 2);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [NB-1:0]     tx_sh_q, tx_sh_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              txready_q, txready_d;
  logic              soclk_q, soclk_d;
  logic              sdout_q, sdout_d;
  logic [NB-1:0]     tx_frame;

  always_comb begin
    tx_frame = '1;
    tx_frame[0] = 1'b0;
    tx_frame[DATA_W:1] = PDin;
    if (PARITY != 0) tx_frame[DATA_W+1] = (^PDin) ^ PAR_ODD;

    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    div_d      = div_q;
    bit_d      = bit_q;
    txready_d  = txready_q;
    soclk_d    = soclk_q;
    sdout_d    = sdout_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (Send) begin
          tx_state_d = TX_SHIFT;
          tx_sh_d    = {1'b1, tx_frame[NB-1:1]};
          sdout_d    = tx_frame[0];
          div_d      = '0;
          bit_d      = '0;
          txready_d  = 1'b0;
          soclk_d    = 1'b0;
        end
      end
      default: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_HALF) soclk_d = 1'b1;
        // Bit boundary: SDout only ever changes together with SoClk falling.
        if (div_q == DIV_END) begin
          div_d   = '0;
          soclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            tx_state_d = TX_IDLE;
            sdout_d    = 1'b1;
            txready_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            sdout_d = tx_sh_q[0];
            tx_sh_d = {1'b1, tx_sh_q[NB-1:1]};
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '1;
      div_q      <= '0;
      bit_q      <= '0;
      txready_q  <= 1'b1;
      soclk_q    <= 1'b0;
      sdout_q    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      txready_q  <= txready_d;
      soclk_q    <= soclk_d;
      sdout_q    <= sdout_d;
    end
  end

  assign TxReady = txready_q;
  assign SoClk   = soclk_q;
  assign SDout   = sdout_q;

  logic sc_meta_q, sc_sync_q, sc_prev_q, sd_meta_q, sd_sync_q;
  logic strobe;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sc_meta_q <= 1'b0;
      sc_sync_q <= 1'b0;
      sc_prev_q <= 1'b0;
      sd_meta_q <= 1'b1;
      sd_sync_q <= 1'b1;
    end else begin
      sc_meta_q <= SCin;
      sc_sync_q <= sc_meta_q;
      sc_prev_q <= sc_sync_q;
      sd_meta_q <= SDin;
      sd_sync_q <= sd_meta_q;
    end
  end

  assign strobe = sc_sync_q & ~sc_prev_q;

  rx_state_e         rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, rx_shifted;
  logic [RXC_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              par_err_q, par_err_d;
  logic [DATA_W-1:0] pdout_q, pdout_d;
  logic              pdready_q, pdready_d;
  logic              parerr_q, parerr_d;
  logic              frameerr_q, frameerr_d;

  always_comb begin
    rx_shifted = rx_sh_q >> 1;
    rx_shifted[DATA_W-1] = sd_sync_q;

    rx_state_d = rx_state_q;
    rx_sh_d    = rx_sh_q;
    rx_cnt_d   = rx_cnt_q;
    to_cnt_d   = to_cnt_q;
    par_err_d  = par_err_q;
    pdout_d    = pdout_q;
    pdready_d  = 1'b0;
    parerr_d   = parerr_q;
    frameerr_d = frameerr_q;

    case (rx_state_q)
      RX_IDLE: begin
        if (strobe && !sd_sync_q) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = '0;
          to_cnt_d   = '0;
          par_err_d  = 1'b0;
        end
      end
      RX_DATA: begin
        if (strobe) begin
          rx_sh_d  = rx_shifted;
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_q == DATA_LAST) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
        end
      end
      RX_PAR: begin
        if (strobe) begin
          par_err_d  = sd_sync_q ^ (^rx_sh_q) ^ PAR_ODD;
          rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (strobe) begin
          pdout_d    = rx_sh_q;
          parerr_d   = par_err_q;
          frameerr_d = ~sd_sync_q;
          pdready_d  = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
    endcase

    // Abort a stalled frame; the published outputs are left untouched.
    if (rx_state_q != RX_IDLE) begin
      if (strobe) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_sh_q    <= '0;
      rx_cnt_q   <= '0;
      to_cnt_q   <= '0;
      par_err_q  <= 1'b0;
      pdout_q    <= '0;
      pdready_q  <= 1'b0;
      parerr_q   <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_sh_q    <= rx_sh_d;
      rx_cnt_q   <= rx_cnt_d;
      to_cnt_q   <= to_cnt_d;
      par_err_q  <= par_err_d;
      pdout_q    <= pdout_d;
      pdready_q  <= pdready_d;
      parerr_q   <= parerr_d;
      frameerr_q <= frameerr_d;
    end
  end

  assign PDout    = pdout_q;
  assign PDready  = pdready_q;
  assign ParErr   = parerr_q;
  assign FrameErr = frameerr_q;

endmodule

// File: tb/tb_serial_link_xcvr.sv
// tb/tb_serial_link_xcvr.sv - directed loopback bench for serial_link_xcvr (even and odd parity instances)
module tb_serial_link_xcvr;

  logic       Clk = 1'b0;
  logic       Rst_n, Send;
  logic [7:0] PDin;
  logic       TxReady, SoClk, SDout, SCin, SDin, PDready, ParErr, FrameErr;
  logic [7:0] PDout;
  logic       o_TxReady, o_SoClk, o_SDout, o_SCin, o_SDin, o_PDready, o_ParErr, o_FrameErr;
  logic [7:0] o_PDout;
  logic       sc_hold = 1'b0, sd_inv = 1'b0, sd_zero = 1'b0;

  int n_cmp = 0, n_err = 0;
  int pdr_cnt = 0, opdr_cnt = 0;
  int low, pdr_k, pdr_hi, base, k, npd, low_total;
  logic par, opar, tr88, tr89;
  logic [7:0] got [2];

  always #5 Clk = ~Clk;

  assign SCin   = sc_hold ? 1'b0 : SoClk;
  assign SDin   = sd_inv ? ~SDout : (sd_zero ? 1'b0 : SDout);
  assign o_SCin = o_SoClk;
  assign o_SDin = o_SDout;

  serial_link_xcvr #(.DATA_W(8), .CLK_DIV(4), .PARITY(1), .RX_TIMEOUT(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Send(Send), .PDin(PDin), .TxReady(TxReady), .SoClk(SoClk),
    .SDout(SDout), .SCin(SCin), .SDin(SDin), .PDout(PDout), .PDready(PDready),
    .ParErr(ParErr), .FrameErr(FrameErr));

  serial_link_xcvr #(.DATA_W(8), .CLK_DIV(4), .PARITY(2), .RX_TIMEOUT(16)) dut_odd (
    .Clk(Clk), .Rst_n(Rst_n), .Send(Send), .PDin(PDin), .TxReady(o_TxReady), .SoClk(o_SoClk),
    .SDout(o_SDout), .SCin(o_SCin), .SDin(o_SDin), .PDout(o_PDout), .PDready(o_PDready),
    .ParErr(o_ParErr), .FrameErr(o_FrameErr));

  always @(posedge Clk) begin
    if (PDready) pdr_cnt++;
    if (o_PDready) opdr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 1 inverts SDin over the parity bit, mode 2 forces SDin low over the stop bit
  task automatic send_frame(input logic [7:0] data, input int mode);
    int kk;
    Send = 1'b1; PDin = data;
    @(posedge Clk); #1;
    Send = 1'b0;
    kk = 0; low = 0; pdr_k = -1; pdr_hi = 0;
    while (kk <= 200 && TxReady === 1'b0) begin
      low++;
      if (mode == 1 && kk == 72) sd_inv = 1'b1;
      if (mode == 1 && kk == 80) sd_inv = 1'b0;
      if (mode == 2 && kk == 80) sd_zero = 1'b1;
      if (kk == 76) begin par = SDout; opar = o_SDout; end
      if (PDready) begin pdr_hi++; if (pdr_k < 0) pdr_k = kk; end
      @(posedge Clk); #1;
      kk++;
    end
    if (PDready) begin pdr_hi++; if (pdr_k < 0) pdr_k = kk; end
    sd_inv = 1'b0; sd_zero = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst_n = 1'b0; Send = 1'b0; PDin = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_txready", TxReady, 1);
    chk("rst_soclk", SoClk, 0);
    chk("rst_sdout", SDout, 1);
    chk("rst_pdout", PDout, 0);
    chk("rst_pdready", PDready, 0);
    chk("rst_parerr", ParErr, 0);
    chk("rst_frameerr", FrameErr, 0);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;

    base = pdr_cnt;
    send_frame(8'hA5, 0);
    chk("a5_txready_low", low, 88);
    chk("a5_parity_bit", par, 0);
    chk("a5_pdout", PDout, 8'hA5);
    chk("a5_parerr", ParErr, 0);
    chk("a5_frameerr", FrameErr, 0);
    chk("a5_pdready_width", pdr_hi, 1);
    chk("a5_latency_ok", (pdr_k >= 85 && pdr_k <= 88), 1);
    chk("a5_idle_sdout", SDout, 1);
    chk("a5_idle_soclk", SoClk, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("a5_pdready_count", pdr_cnt - base, 1);

    base = opdr_cnt;
    send_frame(8'h01, 0);
    chk("p01_even_bit", par, 1);
    chk("p01_odd_bit", opar, 0);
    chk("p01_even_parerr", ParErr, 0);
    chk("p01_odd_parerr", o_ParErr, 0);
    chk("p01_odd_pdout", o_PDout, 8'h01);
    chk("p01_even_pdout", PDout, 8'h01);
    repeat (3) @(posedge Clk);
    #1;
    chk("p01_odd_pdready_count", opdr_cnt - base, 1);

    send_frame(8'h3C, 1);
    chk("perr_pdout", PDout, 8'h3C);
    chk("perr_parerr", ParErr, 1);
    chk("perr_frameerr", FrameErr, 0);
    repeat (3) @(posedge Clk);
    #1;

    send_frame(8'h3C, 2);
    chk("ferr_frameerr", FrameErr, 1);
    chk("ferr_parerr", ParErr, 0);
    chk("ferr_pdout", PDout, 8'h3C);
    chk("ferr_pdready", pdr_hi, 1);
    repeat (3) @(posedge Clk);
    #1;

    Send = 1'b1; PDin = 8'h3C;
    @(posedge Clk); #1;
    k = 0; npd = 0; low_total = 0; tr88 = 1'b0; tr89 = 1'b1;
    while (k < 190) begin
      if (k == 20) PDin = 8'hC3;
      if (k == 88) tr88 = TxReady;
      if (k == 89) begin tr89 = TxReady; Send = 1'b0; end
      if (TxReady === 1'b0) low_total++;
      if (PDready) begin
        if (npd < 2) got[npd] = PDout;
        npd++;
      end
      @(posedge Clk); #1;
      k++;
    end
    chk("b2b_gap_high", tr88, 1);
    chk("b2b_restart_low", tr89, 0);
    chk("b2b_low_total", low_total, 176);
    chk("b2b_pdready_count", npd, 2);
    chk("b2b_word0", got[0], 8'h3C);
    chk("b2b_word1", got[1], 8'hC3);
    chk("b2b_final_txready", TxReady, 1);

    Send = 1'b1; PDin = 8'h99;
    @(posedge Clk); #1;
    Send = 1'b0;
    repeat (36) @(posedge Clk);
    #1;
    base = pdr_cnt;
    Rst_n = 1'b0;
    #1;
    chk("mrst_sdout", SDout, 1);
    chk("mrst_soclk", SoClk, 0);
    chk("mrst_txready", TxReady, 1);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    chk("mrst_no_pdready", pdr_cnt - base, 0);
    chk("mrst_pdout_cleared", PDout, 0);
    send_frame(8'h5A, 0);
    chk("mrst_next_pdout", PDout, 8'h5A);
    chk("mrst_next_low", low, 88);
    chk("mrst_next_pdready", pdr_hi, 1);
    repeat (3) @(posedge Clk);
    #1;

    Send = 1'b1; PDin = 8'hFF;
    @(posedge Clk); #1;
    Send = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    sc_hold = 1'b1;
    base = pdr_cnt;
    k = 0;
    while (k < 200 && TxReady === 1'b0) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("to_tx_finished", TxReady, 1);
    sc_hold = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    chk("to_no_pdready", pdr_cnt - base, 0);
    chk("to_pdout_held", PDout, 8'h5A);
    send_frame(8'h77, 0);
    chk("to_next_pdout", PDout, 8'h77);
    chk("to_next_parerr", ParErr, 0);
    chk("to_next_frameerr", FrameErr, 0);
    chk("to_next_pdready", pdr_hi, 1);

    repeat (4) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_link_xcvr.md
Name: serial_link_xcvr

Overview:
- Parametrised successor to the V1/V2 serial transmitter/receiver pair. Combines one transmitter and one receiver in a single clock domain.
- Generalised in word width, parity mode and serial bit rate. Adds framing (start/stop), a ready handshake, frame-error detection and a receiver abort timeout.
- Used on-board in loopback (SoClk->SCin, SDout->SDin) or between two boards.

Parameters:
DATA_W, 8, payload bits per frame (1..32)
CLK_DIV, 4, Clk cycles per serial-clock half period (>=2)
PARITY, 1, 0 = none, 1 = even, 2 = odd
RX_TIMEOUT, 16, Clk cycles without an SCin rising edge before a mid-frame receive aborts (> 2*CLK_DIV)

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
Send  input  1  transmit request, sampled on Clk rising edge
PDin  input  DATA_W  parallel transmit data
TxReady  output  1  transmitter idle, Send accepted
SoClk  output  1  serial clock out
SDout  output  1  serial data out
SCin  input  1  serial clock in (asynchronous)
SDin  input  1  serial data in (asynchronous)
PDout  output  DATA_W  last received word
PDready  output  1  one-cycle pulse when a frame is received
ParErr  output  1  parity error of the last frame
FrameErr  output  1  stop bit of the last frame was 0

Behaviour:
- Reset (async assert, sync release): TxReady=1, SoClk=0, SDout=1, PDout=0, PDready=0, ParErr=0, FrameErr=0. Both state machines go to IDLE. Reset mid-frame aborts the frame; no PDready is produced.
- Frame format: start bit (0), DATA_W data bits LSB first, parity bit (only when PARITY!=0), stop bit (1). NB = DATA_W+2+(PARITY!=0).
- Parity bit: even mode = XOR of data bits; odd mode = inverted XOR of data bits.
- TX FSM: IDLE -> SHIFT -> IDLE.
  - IDLE: a rising edge with Send=1 captures PDin into the shift register. TxReady goes 0, SDout takes the start bit and SoClk=0, all registered at that edge.
  - Each bit lasts 2*CLK_DIV cycles. SoClk is 0 for the first CLK_DIV cycles and 1 for the second. SDout changes only at bit boundaries, i.e. on SoClk falling.
  - After NB bit periods: SDout=1, SoClk=0, TxReady=1.
  - TxReady is low for exactly NB*2*CLK_DIV cycles per frame.
  - Send held high with TxReady=1 starts the next frame immediately: back-to-back frames, each re-capturing PDin.
  - Send while TxReady=0 is ignored; PDin changes mid-frame have no effect.
  - SoClk stays 0 in IDLE (gated serial clock).
- RX: SCin and SDin each pass through a 2-flop synchroniser. A rising-edge detect on synchronised SCin produces a sample strobe, and the synchronised SDin is captured on that strobe.
- RX FSM: IDLE -> DATA -> (PAR) -> STOP -> IDLE.
  - IDLE: a strobe with SDin=0 moves to DATA. A strobe with SDin=1 is ignored.
  - DATA: DATA_W samples are shifted in LSB first.
  - PAR: the parity sample is compared with the computed parity.
  - STOP: on the stop-bit strobe, PDout, ParErr and FrameErr update together. PDready is 1 on the next cycle only. The FSM returns to IDLE.
  - ParErr is always 0 when PARITY=0.
  - PDout, ParErr and FrameErr hold until the next completed frame.
- Timeout: in DATA, PAR or STOP, an idle counter reloads on each strobe. After RX_TIMEOUT cycles without a strobe the RX returns to IDLE. Outputs are unchanged and no PDready is produced.
- End-to-end latency in loopback: PDready is asserted at most 4 cycles after SoClk rises for the stop bit.
- TX and RX are independent: full duplex is allowed.

Test Plan:
- DATA_W=8, CLK_DIV=4, PARITY=1, loopback; Send pulse with PDin=0xA5 -> parity bit 0; TxReady low for 88 cycles; PDout=0xA5, PDready single pulse, ParErr=0, FrameErr=0.
- PARITY=1 then PARITY=2, PDin=0x01 -> transmitted parity bit 1 (even) / 0 (odd); receiver ParErr=0 in both.
- Loopback with SDin forced inverted during the parity bit period, PDin=0x3C -> PDout=0x3C, ParErr=1. Separately, forcing SDin=0 during the stop bit -> FrameErr=1.
- Send held high, PDin=0x3C, then changed to 0xC3 during frame 1 -> two contiguous 88-cycle frames with TxReady high for one cycle between them; PDout sequence 0x3C, 0xC3; two PDready pulses.
- Rst_n low for 2 cycles during data bit 3 -> SDout=1, SoClk=0, TxReady=1 immediately and no PDready. A following Send of 0x5A is received correctly.
- SCin stopped (held 0) after 4 data bits -> no PDready; RX back in IDLE after 16 cycles; next full frame with 0x77 is received with PDout=0x77.
